// File: rtl/vjtag_burst_bridge.sv
// Virtual-JTAG DR scans bridged to a zero-latency memory port; everything runs on tck.
// Define VJTAG_IDCODE_EN to make IR 7 return ID_VALUE instead of acting as BYPASS.
module vjtag_burst_bridge #(
  parameter int DW  = 8,
  parameter int AW  = 16,
  parameter int IRW = 3
`ifdef VJTAG_IDCODE_EN
  ,
  parameter logic [31:0] ID_VALUE = 32'h5642_4252
`endif
) (
  input  logic           tck,
  input  logic           aclr,
  input  logic           tdi,
  output logic           tdo,
  input  logic [IRW-1:0] ir_in,
  input  logic           v_cdr,
  input  logic           v_sdr,
  input  logic           v_udr,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [DW-1:0]  mem_rdata
);

`ifdef VJTAG_IDCODE_EN
  localparam int SW0 = (DW > AW) ? DW : AW;
  localparam int SW  = (SW0 > 32) ? SW0 : 32;
  localparam logic [IRW-1:0] IR_IDCODE = IRW'(3'd7);
`else
  localparam int SW  = (DW > AW) ? DW : AW;
`endif
  localparam int CW  = $clog2(DW);

  localparam logic [IRW-1:0] IR_WRITE     = IRW'(3'd1);
  localparam logic [IRW-1:0] IR_READ      = IRW'(3'd2);
  localparam logic [IRW-1:0] IR_SET_ADDR  = IRW'(3'd3);
  localparam logic [IRW-1:0] IR_WRITE_INC = IRW'(3'd4);
  localparam logic [IRW-1:0] IR_READ_INC  = IRW'(3'd5);
  localparam logic [IRW-1:0] IR_ADDR_RD   = IRW'(3'd6);

  logic [SW-1:0] shreg_r, shreg_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [DW-1:0] wdata_r, wdata_s;
  logic          we_pend_r, we_pend_s;
  logic          we_inc_r, we_inc_s;
  logic          bypass_r, bypass_s;
  logic          re_s;
  logic          use_bypass_s;
  int            len_s;

  // Each instruction's DR length decides where tdi enters, so a full scan lands the word at bit 0.
  function automatic logic [SW-1:0] shift_in(input logic [SW-1:0] sh, input logic b, input int len);
    logic [SW-1:0] keep;
    keep = ~({SW{1'b1}} << (len - 1));
    return ((sh >> 1) & keep) | ({{(SW-1){1'b0}}, b} << (len - 1));
  endfunction

  // Instruction decode: scan length and whether tdo comes from the bypass bit
  always_comb begin
    use_bypass_s = 1'b0;
    len_s        = SW;
    case (ir_in)
      IR_WRITE, IR_READ, IR_WRITE_INC, IR_READ_INC: len_s = DW;
      IR_SET_ADDR, IR_ADDR_RD:                      len_s = AW;
`ifdef VJTAG_IDCODE_EN
      IR_IDCODE:                                    len_s = 32'sd32;
`endif
      default:                                      use_bypass_s = 1'b1;
    endcase
  end

  // Next-state logic for the shared scan datapath, address and memory strobes
  always_comb begin
    shreg_s   = shreg_r;
    cnt_s     = cnt_r;
    addr_s    = (we_pend_r && we_inc_r) ? addr_r + AW'(1) : addr_r;
    wdata_s   = wdata_r;
    we_pend_s = 1'b0;
    we_inc_s  = 1'b0;
    bypass_s  = bypass_r;
    re_s      = 1'b0;
    if (v_cdr) begin
      cnt_s    = {CW{1'b0}};
      bypass_s = 1'b0;
      case (ir_in)
        IR_READ: begin
          shreg_s = SW'(mem_rdata);
          re_s    = 1'b1;
        end
        IR_READ_INC: begin
          shreg_s = SW'(mem_rdata);
          re_s    = 1'b1;
          addr_s  = addr_s + AW'(1);
        end
        IR_ADDR_RD: shreg_s = SW'(addr_r);
`ifdef VJTAG_IDCODE_EN
        IR_IDCODE:  shreg_s = SW'(ID_VALUE);
`endif
        default:    shreg_s = shreg_r;
      endcase
    end else if (v_sdr) begin
      bypass_s = tdi;
      shreg_s  = shift_in(shreg_r, tdi, len_s);
      if (cnt_r == CW'(DW - 1)) begin
        cnt_s = {CW{1'b0}};
        case (ir_in)
          IR_WRITE_INC: begin
            wdata_s   = {tdi, shreg_r[DW-1:1]};
            we_pend_s = 1'b1;
            we_inc_s  = 1'b1;
          end
          // Prefetch the next word from the already-advanced address
          IR_READ_INC: begin
            shreg_s = SW'(mem_rdata);
            re_s    = 1'b1;
            addr_s  = addr_s + AW'(1);
          end
          default: cnt_s = {CW{1'b0}};
        endcase
      end else begin
        cnt_s = cnt_r + CW'(1);
      end
    end else if (v_udr) begin
      case (ir_in)
        IR_WRITE: begin
          wdata_s   = shreg_r[DW-1:0];
          we_pend_s = 1'b1;
        end
        IR_SET_ADDR: begin
          addr_s = shreg_r[AW-1:0];
          cnt_s  = {CW{1'b0}};
        end
        default: we_pend_s = 1'b0;
      endcase
    end else begin
      re_s = 1'b0;
    end
  end

  // State registers; reset drops any pending write
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      shreg_r   <= {SW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      we_pend_r <= 1'b0;
      we_inc_r  <= 1'b0;
      bypass_r  <= 1'b0;
    end else begin
      shreg_r   <= shreg_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      we_pend_r <= we_pend_s;
      we_inc_r  <= we_inc_s;
      bypass_r  <= bypass_s;
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = we_pend_r;
  assign mem_re    = re_s & aclr;
  assign tdo       = use_bypass_s ? bypass_r : shreg_r[0];

endmodule

// File: tb/tb_vjtag_burst_bridge.sv
// Randomized bench for vjtag_burst_bridge: scans driven per tck, checked against a word-level model.
module tb_vjtag_burst_bridge;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int IRW = 3;

  logic           tck = 1'b0;
  logic           aclr = 1'b0;
  logic           tdi = 1'b0;
  logic           tdo;
  logic [IRW-1:0] ir_in = 3'd0;
  logic           v_cdr = 1'b0;
  logic           v_sdr = 1'b0;
  logic           v_udr = 1'b0;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic [DW-1:0]  mem_rdata;

  logic [DW-1:0]  ram     [0:65535];
  logic [DW-1:0]  ref_mem [0:65535];
  logic [AW-1:0]  we_a_q[$];
  logic [DW-1:0]  we_d_q[$];
  int             vec_cnt = 0;
  int             err_cnt = 0;
  int             re_cnt = 0;
  int             overlap_cnt = 0;
  logic           tdo_smp;

  vjtag_burst_bridge #(.DW(DW), .AW(AW), .IRW(IRW)) dut (
    .tck(tck), .aclr(aclr), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 tck = ~tck;
  assign mem_rdata = ram[mem_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // one tck: drive at negedge, sample 1 unit later, log strobes
  task automatic step(input logic cdr, input logic sdr, input logic udr, input logic d);
    @(negedge tck);
    v_cdr = cdr; v_sdr = sdr; v_udr = udr; tdi = d;
    #1;
    tdo_smp = tdo;
    if (mem_we) begin
      we_a_q.push_back(mem_addr);
      we_d_q.push_back(mem_wdata);
      ram[mem_addr] = mem_wdata;
    end
    if (mem_re) re_cnt++;
    if (mem_we && mem_re) overlap_cnt++;
  endtask

  task automatic scan(input logic [IRW-1:0] ir, input int n, input logic [63:0] din,
                      output logic [63:0] dout);
    ir_in = ir;
    dout = 64'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, din[i]);
      dout[i] = tdo_smp;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    logic [63:0] d;
    scan(3'd3, AW, {48'd0, a}, d);
  endtask

  task automatic read_addr(output logic [AW-1:0] a);
    logic [63:0] d;
    scan(3'd6, AW, {$urandom, $urandom}, d);
    a = d[AW-1:0];
  endtask

  task automatic test_reset();
    logic [AW-1:0] got;
    #2;
    vec_cnt++;
    if ({tdo, mem_addr, mem_wdata, mem_we, mem_re} !== 27'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs got tdo=%b addr=%h wdata=%h we=%b re=%b exp all 0",
               tdo, mem_addr, mem_wdata, mem_we, mem_re);
    end
    @(negedge tck);
    aclr = 1'b1;
    read_addr(got);
    vec_cnt++;
    if (got !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_addr got %h exp 0000", got);
    end
  endtask

  task automatic test_read_inc();
    logic [63:0] din, dout, expv, mask;
    logic [AW-1:0] a, got;
    logic [DW-1:0] w;
    int n;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        a = 16'h0020; n = 24;
      end else begin
        a = AW'($urandom); n = int'($urandom_range(1, 40));
      end
      din = {$urandom, $urandom};
      set_addr(a);
      re_cnt = 0;
      scan(3'd5, n, din, dout);
      expv = 64'd0;
      for (int i = 0; i < n; i++) begin
        w = ref_mem[AW'(int'(a) + i / DW)];
        expv[i] = w[i % DW];
      end
      mask = (64'd1 << n) - 64'd1;
      vec_cnt++;
      if ((dout & mask) !== expv) begin
        err_cnt++;
        $display("FAIL read_inc_data it=%0d got %h exp %h", it, dout & mask, expv);
      end
      vec_cnt++;
      if (re_cnt != 1 + n / DW) begin
        err_cnt++;
        $display("FAIL read_inc_re it=%0d got %0d exp %0d", it, re_cnt, 1 + n / DW);
      end
      read_addr(got);
      vec_cnt++;
      if (got !== AW'(int'(a) + 1 + n / DW)) begin
        err_cnt++;
        $display("FAIL read_inc_addr it=%0d got %h exp %h", it, got, AW'(int'(a) + 1 + n / DW));
      end
    end
  endtask

  task automatic test_write_inc();
    logic [63:0] din, dout;
    logic [AW-1:0] a, got, ea;
    logic [DW-1:0] ed;
    int nw;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        a = 16'h0010; nw = 4; din = 64'h0000_0000_4433_2211;
      end else begin
        a = AW'($urandom); nw = int'($urandom_range(1, 6)); din = {$urandom, $urandom};
      end
      set_addr(a);
      we_a_q.delete(); we_d_q.delete();
      scan(3'd4, nw * DW, din, dout);
      vec_cnt++;
      if (we_a_q.size() != nw) begin
        err_cnt++;
        $display("FAIL write_inc_count it=%0d got %0d exp %0d", it, we_a_q.size(), nw);
      end
      for (int k = 0; k < nw; k++) begin
        ea = AW'(int'(a) + k);
        ed = din[k*DW +: DW];
        ref_mem[ea] = ed;
        vec_cnt++;
        if (k >= we_a_q.size()) begin
          err_cnt++;
          $display("FAIL write_inc_word it=%0d k=%0d got none exp %h@%h", it, k, ed, ea);
        end else if (we_a_q[k] !== ea || we_d_q[k] !== ed) begin
          err_cnt++;
          $display("FAIL write_inc_word it=%0d k=%0d got %h@%h exp %h@%h",
                   it, k, we_d_q[k], we_a_q[k], ed, ea);
        end
      end
      read_addr(got);
      vec_cnt++;
      if (got !== AW'(int'(a) + nw)) begin
        err_cnt++;
        $display("FAIL write_inc_addr it=%0d got %h exp %h", it, got, AW'(int'(a) + nw));
      end
    end
  endtask

  task automatic test_single();
    logic [63:0] dout;
    logic [AW-1:0] a, got;
    logic [DW-1:0] d;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        a = 16'h00FF; d = 8'h5A;
      end else begin
        a = AW'($urandom); d = DW'($urandom);
      end
      set_addr(a);
      we_a_q.delete(); we_d_q.delete();
      scan(3'd1, DW, {56'd0, d}, dout);
      ref_mem[a] = d;
      vec_cnt++;
      if (we_a_q.size() != 1) begin
        err_cnt++;
        $display("FAIL write_count it=%0d got %0d exp 1", it, we_a_q.size());
      end else if (we_a_q[0] !== a || we_d_q[0] !== d) begin
        err_cnt++;
        $display("FAIL write_word it=%0d got %h@%h exp %h@%h", it, we_d_q[0], we_a_q[0], d, a);
      end
      re_cnt = 0;
      scan(3'd2, DW, {$urandom, $urandom}, dout);
      vec_cnt++;
      if (dout[DW-1:0] !== ref_mem[a] || re_cnt != 1) begin
        err_cnt++;
        $display("FAIL read_word it=%0d got %h re=%0d exp %h re=1", it, dout[DW-1:0], re_cnt, ref_mem[a]);
      end
      read_addr(got);
      vec_cnt++;
      if (got !== a) begin
        err_cnt++;
        $display("FAIL single_addr it=%0d got %h exp %h", it, got, a);
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] din, dout;
    logic [AW-1:0] got;
    din = {$urandom, $urandom};
    set_addr(16'hFFFF);
    we_a_q.delete(); we_d_q.delete();
    scan(3'd4, 2 * DW, din, dout);
    ref_mem[16'hFFFF] = din[7:0];
    ref_mem[16'h0000] = din[15:8];
    vec_cnt++;
    if (we_a_q.size() != 2 || we_a_q[0] !== 16'hFFFF || we_a_q[1] !== 16'h0000 ||
        we_d_q[0] !== din[7:0] || we_d_q[1] !== din[15:8]) begin
      err_cnt++;
      $display("FAIL wrap_writes got n=%0d first=%h@%h exp %h@FFFF,%h@0000",
               we_a_q.size(), (we_d_q.size() > 0) ? we_d_q[0] : 8'h00,
               (we_a_q.size() > 0) ? we_a_q[0] : 16'h0000, din[7:0], din[15:8]);
    end
    read_addr(got);
    vec_cnt++;
    if (got !== 16'h0001) begin
      err_cnt++;
      $display("FAIL wrap_addr got %h exp 0001", got);
    end
    din = {$urandom, $urandom};
    we_a_q.delete(); we_d_q.delete();
    scan(3'd4, 13, din, dout);
    ref_mem[16'h0001] = din[7:0];
    vec_cnt++;
    if (we_a_q.size() != 1 || we_a_q[0] !== 16'h0001 || we_d_q[0] !== din[7:0]) begin
      err_cnt++;
      $display("FAIL partial_write got n=%0d exp 1 word %h@0001", we_a_q.size(), din[7:0]);
    end
    read_addr(got);
    vec_cnt++;
    if (got !== 16'h0002) begin
      err_cnt++;
      $display("FAIL partial_addr got %h exp 0002", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] got;
    set_addr(AW'($urandom) | 16'h0001);
    we_a_q.delete(); we_d_q.delete();
    ir_in = 3'd4;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
    #1;
    aclr = 1'b0;
    #1;
    vec_cnt++;
    if ({tdo, mem_addr, mem_wdata, mem_we, mem_re} !== 27'd0) begin
      err_cnt++;
      $display("FAIL midscan_reset got tdo=%b addr=%h wdata=%h we=%b re=%b exp all 0",
               tdo, mem_addr, mem_wdata, mem_we, mem_re);
    end
    @(posedge tck);
    #1;
    aclr = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    vec_cnt++;
    if (we_a_q.size() != 0) begin
      err_cnt++;
      $display("FAIL midscan_no_write got %0d writes exp 0", we_a_q.size());
    end
    read_addr(got);
    vec_cnt++;
    if (got !== 16'h0000) begin
      err_cnt++;
      $display("FAIL midscan_addr got %h exp 0000", got);
    end
  endtask

  task automatic test_idcode_bypass();
    logic [63:0] din, dout;
    logic [31:0] expv;
    din = {$urandom, $urandom};
    scan(3'd7, 32, din, dout);
`ifdef VJTAG_IDCODE_EN
    expv = 32'h5642_4252;
`else
    expv = {din[30:0], 1'b0};
`endif
    vec_cnt++;
    if (dout[31:0] !== expv) begin
      err_cnt++;
      $display("FAIL ir7_scan got %h exp %h", dout[31:0], expv);
    end
    din = {$urandom, $urandom};
    scan(3'd0, 32, din, dout);
    expv = {din[30:0], 1'b0};
    vec_cnt++;
    if (dout[31:0] !== expv) begin
      err_cnt++;
      $display("FAIL bypass_scan got %h exp %h", dout[31:0], expv);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'hA0 + 8'(i);
      ref_mem[i] = 8'hA0 + 8'(i);
    end
    test_reset();
    test_read_inc();
    test_write_inc();
    test_single();
    test_wrap();
    test_reset_mid();
    test_idcode_bypass();
    vec_cnt++;
    if (overlap_cnt != 0) begin
      err_cnt++;
      $display("FAIL we_re_overlap got %0d cycles exp 0", overlap_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
